// File: rtl/tile_spawner.sv
// New-tile spawner for the 2048 game: counts empty cells, picks one with a
// free-running LFSR and emits a single-cell write (or reports a full board).
module tile_spawner #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter logic [3:0]  FOUR_ODDS = 4'd2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] mat_flat,
    output logic        busy,
    output logic        wr_en,
    output logic [1:0]  wr_row,
    output logic [1:0]  wr_col,
    output logic [3:0]  wr_val,
    output logic        done,
    output logic        full
);

    localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        COUNT  = 3'd1,
        REDUCE = 3'd2,
        SEEK   = 3'd3,
        WRITE  = 3'd4,
        FULL   = 3'd5
    } state_t;

    state_t      state, state_nx;
    logic [3:0]  idx, idx_nx;
    logic [4:0]  cnt, cnt_nx;
    logic [3:0]  tgt, tgt_nx;
    logic [15:0] lfsr, lfsr_nx;
    logic [1:0]  row_nx, col_nx;
    logic [3:0]  val_nx;
    logic        cell_empty;
    logic [4:0]  cnt_sum;

    // cell (i,j) sits at bit 16*i + 4*j, which is simply 4*idx in scan order
    assign cell_empty = (mat_flat[{idx, 2'b00} +: 4] == 4'd0);
    assign cnt_sum    = cnt + {4'd0, cell_empty};
    assign lfsr_nx    = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= 4'd0;
            cnt    <= 5'd0;
            tgt    <= 4'd0;
            lfsr   <= SEED_EFF;
            wr_row <= 2'd0;
            wr_col <= 2'd0;
            wr_val <= 4'd0;
        end else begin
            state  <= state_nx;
            idx    <= idx_nx;
            cnt    <= cnt_nx;
            tgt    <= tgt_nx;
            lfsr   <= lfsr_nx;
            wr_row <= row_nx;
            wr_col <= col_nx;
            wr_val <= val_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        cnt_nx   = cnt;
        tgt_nx   = tgt;
        row_nx   = wr_row;
        col_nx   = wr_col;
        val_nx   = wr_val;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = COUNT;
                    idx_nx   = 4'd0;
                    cnt_nx   = 5'd0;
                end
            end
            COUNT: begin
                cnt_nx = cnt_sum;
                idx_nx = idx + 4'd1;
                if (idx == 4'd15) begin
                    if (cnt_sum == 5'd0) begin
                        state_nx = FULL;
                    end else begin
                        state_nx = REDUCE;
                        tgt_nx   = lfsr[3:0];
                        val_nx   = (lfsr[7:4] < FOUR_ODDS) ? 4'd2 : 4'd1;
                    end
                end
            end
            REDUCE: begin
                // repeated subtraction gives tgt mod cnt without a divider
                if ({1'b0, tgt} >= cnt) begin
                    tgt_nx = tgt - cnt[3:0];
                end else begin
                    state_nx = SEEK;
                    idx_nx   = 4'd0;
                end
            end
            SEEK: begin
                idx_nx = idx + 4'd1;
                if (cell_empty) begin
                    if (tgt == 4'd0) begin
                        row_nx   = idx[3:2];
                        col_nx   = idx[1:0];
                        state_nx = WRITE;
                    end else begin
                        tgt_nx = tgt - 4'd1;
                    end
                end
            end
            WRITE:   state_nx = IDLE;
            FULL:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy  = (state != IDLE);
    assign wr_en = (state == WRITE);
    assign done  = (state == WRITE) || (state == FULL);
    assign full  = (state == FULL);

endmodule
